// File: rtl/soc_cpu_membus.sv
// soc_cpu_membus: routes the PicoRV32 native bus to one IMEM port plus N_SLV windowed data targets.
// Adds unmapped/timeout/write-to-IMEM error responses. Optional counters: SOC_CPU_MEMBUS_STATS_EN.
module soc_cpu_membus #(
    parameter int unsigned         N_SLV         = 4,
    parameter logic [32*N_SLV-1:0] SLV_BASE      = {N_SLV{32'h0}},
    parameter logic [32*N_SLV-1:0] SLV_MASK      = {N_SLV{32'h0}},
    parameter bit                  INSTR_TO_IMEM = 1'b1,
    parameter int unsigned         TIMEOUT_CYC   = 255,
    parameter logic [31:0]         ERR_RDAT      = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_valid,
    input  logic                 cpu_instr,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_wstrb,
    output logic                 cpu_ready,
    output logic [31:0]          cpu_rdata,
    output logic                 imem_vld,
    output logic [29:0]          imem_addr,
    input  logic                 imem_rdy,
    input  logic [31:0]          imem_rdat,
    output logic [N_SLV-1:0]     slv_vld,
    output logic [3:0]           slv_we,
    output logic [29:0]          slv_addr,
    output logic [31:0]          slv_wdat,
    input  logic [N_SLV-1:0]     slv_rdy,
    input  logic [32*N_SLV-1:0]  slv_rdat,
    output logic                 err_pulse,
    output logic [31:0]          err_addr,
    output logic [1:0]           err_kind,
    output logic [31:0]          stat_rd,
    output logic [31:0]          stat_wr,
    output logic [31:0]          stat_fetch
);
    localparam int unsigned   CW         = 16;
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    EK_NONE    = 2'd0;
    localparam logic [1:0]    EK_UNMAP   = 2'd1;
    localparam logic [1:0]    EK_TIMEOUT = 2'd2;
    localparam logic [1:0]    EK_WRIMEM  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               sel_imem_q, sel_imem_d;
    logic [N_SLV-1:0]   sel_q, sel_d;
    logic [1:0]         ekind_q, ekind_d;
    logic               wait_q, wait_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               imem_vld_d, cpu_ready_d, err_pulse_d;
    logic [N_SLV-1:0]   slv_vld_d;
    logic [31:0]        cpu_rdata_d, err_addr_d;
    logic [1:0]         err_kind_d;
    logic [N_SLV-1:0]   dec_sel;
    logic               dec_imem;
    logic [1:0]         dec_err;
    logic               sel_rdy, timeout, resp_go;
    logic [31:0]        sel_rdat;
    logic [1:0]         resp_kind;

    // Address decode of the live request; the lowest-index window wins on overlap.
    always_comb begin
        dec_sel  = '0;
        dec_imem = 1'b0;
        for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
            if ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])
                dec_sel = N_SLV'(1) << i;
        end
        if (cpu_instr && INSTR_TO_IMEM) begin
            dec_sel  = '0;
            dec_imem = 1'b1;
        end else if (dec_sel == '0 && cpu_instr && cpu_wstrb == 4'd0) begin
            dec_imem = 1'b1;
        end
        dec_err = EK_NONE;
        if (!dec_imem && dec_sel == '0)
            dec_err = EK_UNMAP;
        else if (dec_imem && cpu_wstrb != 4'd0)
            dec_err = EK_WRIMEM;
    end

    // Ready/data from the selected target only.
    always_comb begin
        sel_rdy  = sel_imem_q & imem_rdy;
        sel_rdat = sel_imem_q ? imem_rdat : 32'd0;
        for (int i = 0; i < int'(N_SLV); i++) begin
            if (sel_q[i]) begin
                sel_rdy  = sel_rdy | slv_rdy[i];
                sel_rdat = sel_rdat | slv_rdat[32*i +: 32];
            end
        end
    end

    assign timeout = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_valid) state_d = (dec_err != EK_NONE) ? RESP : ACCESS;
            ACCESS:  if (sel_rdy || timeout) state_d = RESP;
            RESP:    if (!wait_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode errors hold RESP one extra cycle so every response has the same 2-cycle minimum.
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        sel_imem_d  = sel_imem_q;
        sel_d       = sel_q;
        ekind_d     = ekind_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        imem_vld_d  = 1'b0;
        slv_vld_d   = '0;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata;
        err_pulse_d = 1'b0;
        err_addr_d  = err_addr;
        err_kind_d  = err_kind;
        resp_go     = 1'b0;
        resp_kind   = EK_NONE;
        unique case (state_q)
            IDLE: if (cpu_valid) begin
                addr_d     = cpu_addr;
                wdata_d    = cpu_wdata;
                wstrb_d    = cpu_wstrb;
                sel_imem_d = dec_imem;
                sel_d      = dec_sel;
                ekind_d    = dec_err;
                cnt_d      = '0;
                wait_d     = (dec_err != EK_NONE);
                if (dec_err == EK_NONE) begin
                    imem_vld_d = dec_imem;
                    slv_vld_d  = dec_sel;
                end
            end
            ACCESS: begin
                if (sel_rdy) begin
                    resp_go = 1'b1;
                end else if (timeout) begin
                    resp_go   = 1'b1;
                    resp_kind = EK_TIMEOUT;
                end else begin
                    imem_vld_d = sel_imem_q;
                    slv_vld_d  = sel_q;
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            RESP: if (wait_q) begin
                resp_go   = 1'b1;
                resp_kind = ekind_q;
                wait_d    = 1'b0;
            end
            default: ;
        endcase
        if (resp_go) begin
            cpu_ready_d = 1'b1;
            if (resp_kind != EK_NONE) begin
                cpu_rdata_d = ERR_RDAT;
                err_pulse_d = 1'b1;
                err_addr_d  = addr_q;
                err_kind_d  = resp_kind;
            end else if (wstrb_q != 4'd0) begin
                cpu_rdata_d = 32'd0;
            end else begin
                cpu_rdata_d = sel_rdat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            sel_imem_q <= 1'b0;
            sel_q      <= '0;
            ekind_q    <= EK_NONE;
            wait_q     <= 1'b0;
            cnt_q      <= '0;
            imem_vld   <= 1'b0;
            slv_vld    <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            err_pulse  <= 1'b0;
            err_addr   <= '0;
            err_kind   <= EK_NONE;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            sel_imem_q <= sel_imem_d;
            sel_q      <= sel_d;
            ekind_q    <= ekind_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
            imem_vld   <= imem_vld_d;
            slv_vld    <= slv_vld_d;
            cpu_ready  <= cpu_ready_d;
            cpu_rdata  <= cpu_rdata_d;
            err_pulse  <= err_pulse_d;
            err_addr   <= err_addr_d;
            err_kind   <= err_kind_d;
        end
    end

    assign imem_addr = addr_q[31:2];
    assign slv_addr  = addr_q[31:2];
    assign slv_we    = wstrb_q;
    assign slv_wdat  = wdata_q;

`ifdef SOC_CPU_MEMBUS_STATS_EN
    logic instr_q;

    // Saturating per-type transaction counters, bumped on the response edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= 1'b0;
            stat_rd    <= '0;
            stat_wr    <= '0;
            stat_fetch <= '0;
        end else begin
            if (state_q == IDLE && cpu_valid) instr_q <= cpu_instr;
            if (cpu_ready_d) begin
                if (instr_q) begin
                    if (stat_fetch != 32'hFFFF_FFFF) stat_fetch <= stat_fetch + 32'd1;
                end else if (wstrb_q != 4'd0) begin
                    if (stat_wr != 32'hFFFF_FFFF) stat_wr <= stat_wr + 32'd1;
                end else begin
                    if (stat_rd != 32'hFFFF_FFFF) stat_rd <= stat_rd + 32'd1;
                end
            end
        end
    end
`else
    assign stat_rd    = '0;
    assign stat_wr    = '0;
    assign stat_fetch = '0;
`endif
endmodule

// File: tb/tb_soc_cpu_membus.sv
// Bench for soc_cpu_membus: directed and random transactions against a transaction-level route/latency model.
module tb_soc_cpu_membus;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam logic [31:0] BASE_M [4] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    localparam logic [31:0] MASK_M [4] = '{32'hF000_0000, 32'hE000_0000, 32'hF000_0000, 32'hFFFF_0000};
    localparam logic [127:0] BASE = {BASE_M[3], BASE_M[2], BASE_M[1], BASE_M[0]};
    localparam logic [127:0] MASK = {MASK_M[3], MASK_M[2], MASK_M[1], MASK_M[0]};
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk, rst;
    logic cpu_valid, cpu_instr, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0] cpu_wstrb;
    logic imem_vld, imem_rdy;
    logic [29:0] imem_addr, slv_addr;
    logic [31:0] imem_rdat, slv_wdat;
    logic [N-1:0] slv_vld, slv_rdy;
    logic [3:0] slv_we;
    logic [32*N-1:0] slv_rdat;
    logic err_pulse;
    logic [31:0] err_addr, stat_rd, stat_wr, stat_fetch;
    logic [1:0] err_kind;

    int vectors = 0;
    int miscompares = 0;
    int m_rd = 0, m_wr = 0, m_fetch = 0;
    logic [1:0]  m_ekind = 2'd0;
    logic [31:0] m_eaddr = 32'd0;

    soc_cpu_membus #(
        .N_SLV(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .INSTR_TO_IMEM(1'b1),
        .TIMEOUT_CYC(TO), .ERR_RDAT(ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .imem_vld(imem_vld), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdat(imem_rdat),
        .slv_vld(slv_vld), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdat(slv_wdat),
        .slv_rdy(slv_rdy), .slv_rdat(slv_rdat),
        .err_pulse(err_pulse), .err_addr(err_addr), .err_kind(err_kind),
        .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_fetch(stat_fetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int route(input logic instr, input logic [31:0] a);
        if (instr) return N;
        for (int i = 0; i < N; i++)
            if ((a & MASK_M[i]) == BASE_M[i]) return i;
        return -1;
    endfunction

    task automatic chk_stats();
`ifdef SOC_CPU_MEMBUS_STATS_EN
        chk("stat_rd", stat_rd, 32'(m_rd));
        chk("stat_wr", stat_wr, 32'(m_wr));
        chk("stat_fetch", stat_fetch, 32'(m_fetch));
`else
        chk("stat_rd", stat_rd, 32'd0);
        chk("stat_wr", stat_wr, 32'd0);
        chk("stat_fetch", stat_fetch, 32'd0);
`endif
    endtask

    // One CPU transaction; d = vld cycles before the target answers (-1: never). Called at a negedge.
    task automatic xact(input logic instr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int d, input bit drop_early);
        int tgt, kind, limit, ready_c;
        logic [4:0] selm;
        logic [31:0] rd, exp_rd;
        tgt  = route(instr, a);
        kind = 0;
        if (tgt < 0) kind = 1;
        else if (tgt == N && ws != 4'd0) kind = 3;
        selm  = (tgt >= 0) ? 5'(1 << tgt) : 5'd0;
        limit = 0;
        if (kind == 0) begin
            if (d >= 0 && d < TO) limit = d + 1;
            else begin limit = TO; kind = 2; end
        end
        ready_c = (kind == 1 || kind == 3) ? 2 : limit + 1;
        rd      = $urandom;
        exp_rd  = (kind != 0) ? ERR : ((ws != 4'd0) ? 32'd0 : rd);
        cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws;
        for (int c = 1; c <= ready_c + 1; c++) begin
            @(negedge clk);
            chk("vld", {27'd0, imem_vld, slv_vld},
                {27'd0, (kind == 0 || kind == 2) && c <= limit ? selm : 5'd0});
            chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, c == ready_c});
            chk("err_pulse", {31'd0, err_pulse}, {31'd0, c == ready_c && kind != 0});
            if (c == 1 && limit > 0) begin
                if (selm[4]) chk("imem_addr", {2'b0, imem_addr}, {2'b0, a[31:2]});
                else begin
                    chk("slv_addr", {2'b0, slv_addr}, {2'b0, a[31:2]});
                    chk("slv_we", {28'd0, slv_we}, {28'd0, ws});
                    chk("slv_wdat", slv_wdat, wd);
                end
            end
            if (c == ready_c) begin
                if (kind != 0) begin m_ekind = 2'(kind); m_eaddr = a; end
                if (instr) m_fetch++;
                else if (ws != 4'd0) m_wr++;
                else m_rd++;
                chk("cpu_rdata", cpu_rdata, exp_rd);
                chk("err_kind", {30'd0, err_kind}, {30'd0, m_ekind});
                chk("err_addr", err_addr, m_eaddr);
                chk_stats();
                cpu_valid = 1'b0;
            end
            if (drop_early && c == 1) cpu_valid = 1'b0;
            slv_rdy  = 4'($urandom) & ~selm[3:0];
            imem_rdy = selm[4] ? 1'b0 : 1'($urandom);
            slv_rdat = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < N; i++) if (selm[i]) slv_rdat[32*i +: 32] = rd;
            imem_rdat = selm[4] ? rd : $urandom;
            if (d >= 0 && c == d + 1) begin
                if (selm[4]) imem_rdy = 1'b1;
                else slv_rdy = slv_rdy | selm[3:0];
            end
        end
        slv_rdy = '0; imem_rdy = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int d;
        rst = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        imem_rdy = 1'b0; imem_rdat = '0; slv_rdy = '0; slv_rdat = '0;
        repeat (2) @(negedge clk);
        chk("rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst cpu_rdata", cpu_rdata, 32'd0);
        chk("rst vld", {27'd0, imem_vld, slv_vld}, 32'd0);
        chk("rst slv_addr", {2'b0, slv_addr}, 32'd0);
        chk("rst imem_addr", {2'b0, imem_addr}, 32'd0);
        chk("rst slv_we", {28'd0, slv_we}, 32'd0);
        chk("rst slv_wdat", slv_wdat, 32'd0);
        chk("rst err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst err_kind", {30'd0, err_kind}, 32'd0);
        chk("rst err_addr", err_addr, 32'd0);
        chk_stats();
        rst = 1'b0;
        @(negedge clk);

        xact(1'b1, 32'h0000_0100, 32'd0, 4'h0, 0, 1'b0);          // fetch, minimum latency
        xact(1'b0, 32'h2000_0004, 32'hCAFE_F00D, 4'hF, 3, 1'b0);  // write to target 1
        xact(1'b0, 32'hF000_0000, 32'd0, 4'h0, 0, 1'b0);          // unmapped
        xact(1'b0, 32'h1000_0010, 32'd0, 4'h0, -1, 1'b0);         // timeout
        xact(1'b0, 32'h1000_0020, 32'd0, 4'h0, TO - 1, 1'b0);     // ready at expiry wins
        xact(1'b0, 32'h3000_0000, 32'd0, 4'h0, 1, 1'b0);          // overlap: target 1 beats 2
        xact(1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 0, 1'b0);  // write to IMEM
        xact(1'b0, 32'h4000_1234, 32'd0, 4'h0, 4, 1'b1);          // valid dropped mid-access
        xact(1'b0, 32'h2000_0000, 32'h0BAD_F00D, 4'h1, 0, 1'b0);  // minimum-latency write

        // Reset in the 3rd ACCESS cycle of a target that never answers.
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h2000_0008; cpu_wstrb = 4'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("pre-rst vld", {27'd0, imem_vld, slv_vld}, 32'h2);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_valid = 1'b0;
        chk("mid-rst vld", {27'd0, imem_vld, slv_vld}, 32'd0);
        chk("mid-rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("mid-rst err_kind", {30'd0, err_kind}, 32'd0);
        chk("mid-rst err_addr", err_addr, 32'd0);
        m_rd = 0; m_wr = 0; m_fetch = 0; m_ekind = 2'd0; m_eaddr = 32'd0;
        chk_stats();
        @(negedge clk);
        chk("post-rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
        xact(1'b0, 32'h2000_0008, 32'd0, 4'h0, 1, 1'b0);

        // Counter mix: 5 fetches, 2 more reads, 2 writes (3 reads total with the one above).
        for (int i = 0; i < 5; i++) xact(1'b1, 32'h0000_0400 + 32'(4*i), 32'd0, 4'h0, i % 3, 1'b0);
        for (int i = 0; i < 2; i++) xact(1'b0, 32'h1000_0100 + 32'(4*i), 32'd0, 4'h0, i, 1'b0);
        for (int i = 0; i < 2; i++) xact(1'b0, 32'h4000_0010 + 32'(4*i), $urandom, 4'hC, i + 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       a = {4'h1, 28'($urandom)};
                1:       a = {3'b001, 29'($urandom)};
                2:       a = {16'h4000, 16'($urandom)};
                3:       a = {16'h4001, 16'($urandom)};
                4:       a = {4'h5, 28'($urandom)};
                default: a = {4'hF, 28'($urandom)};
            endcase
            d = int'($urandom_range(0, 9));
            if (d == 9) d = -1;
            xact($urandom_range(0, 3) == 0, a, $urandom,
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), d,
                 $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
